// File: rtl/isa_pkg.sv
// Shared ISA definitions for the operand-fetch stage: widths, instruction
// field positions and opcode decode helpers.
package isa_pkg;

  localparam int REG_W  = 16;
  localparam int NREG   = 16;
  localparam int ADDR_W = 4;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 8;
  localparam int RS1_HI = 7;
  localparam int RS1_LO = 4;
  localparam int RS2_HI = 3;
  localparam int RS2_LO = 0;

  // Ops 0-7 write rd.
  function automatic logic op_writes_rd(input logic [3:0] op);
    return ~op[3];
  endfunction

  // Ops C-F read rd as a third source.
  function automatic logic op_reads_rd(input logic [3:0] op);
    return (op[3:2] == 2'b11);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue of a
// writer and cleared by writeback; reports blocked flags for three addresses.
module reg_scoreboard
  import isa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] q1_addr,
  input  logic [ADDR_W-1:0] q2_addr,
  input  logic [ADDR_W-1:0] q3_addr,
  output logic              q1_block,
  output logic              q2_block,
  output logic              q3_block,
  output logic [NREG-1:0]   busy
);

  localparam logic [NREG-1:0] ONE_HOT0 = {{(NREG-1){1'b0}}, 1'b1};

  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] set_mask_s;
  logic [NREG-1:0] clr_mask_s;
  logic [NREG-1:0] busy_nxt_s;

  // Clear is applied before set so a same-register set/clear leaves it busy.
  always_comb begin
    set_mask_s = set_en ? (ONE_HOT0 << set_addr) : {NREG{1'b0}};
    clr_mask_s = clr_en ? (ONE_HOT0 << clr_addr) : {NREG{1'b0}};
    busy_nxt_s = (busy_r & ~clr_mask_s) | set_mask_s;
  end

  // Busy-bit state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r <= {NREG{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  // A register retiring this cycle is no longer a hazard: its value is bypassed.
  assign q1_block = busy_r[q1_addr] & ~(clr_en & (clr_addr == q1_addr));
  assign q2_block = busy_r[q2_addr] & ~(clr_en & (clr_addr == q2_addr));
  assign q3_block = busy_r[q3_addr] & ~(clr_en & (clr_addr == q3_addr));
  assign busy     = busy_r;

endmodule

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: drives the register file read ports, bypasses
// writeback data, stalls on scoreboard hazards and registers A/B/C operands.
module operand_fetch
  import isa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic [ADDR_W-1:0] rf_rn1,
  output logic [ADDR_W-1:0] rf_rn2,
  output logic [ADDR_W-1:0] rf_rn3,
  output logic              rf_read3,
  input  logic [REG_W-1:0]  rf_a,
  input  logic [REG_W-1:0]  rf_b,
  input  logic [REG_W-1:0]  rf_c,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [REG_W-1:0]  wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_op,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_wr_en,
  output logic [REG_W-1:0]  out_a,
  output logic [REG_W-1:0]  out_b,
  output logic [REG_W-1:0]  out_c,
  output logic [15:0]       stall_cnt
);

  logic [3:0]        op_s;
  logic [ADDR_W-1:0] rd_s;
  logic [ADDR_W-1:0] rs1_s;
  logic [ADDR_W-1:0] rs2_s;
  logic              wr_en_s;
  logic              read3_s;
  logic [REG_W-1:0]  opa_s;
  logic [REG_W-1:0]  opb_s;
  logic [REG_W-1:0]  opc_s;
  logic              blk1_s;
  logic              blk2_s;
  logic              blk3_s;
  logic              hazard_s;
  logic              accept_s;
  logic [NREG-1:0]   busy_s;

  logic              out_valid_r;
  logic [3:0]        out_op_r;
  logic [ADDR_W-1:0] out_rd_r;
  logic              out_wr_en_r;
  logic [REG_W-1:0]  out_a_r;
  logic [REG_W-1:0]  out_b_r;
  logic [REG_W-1:0]  out_c_r;
  logic [15:0]       stall_cnt_r;

  assign op_s    = in_instr[OP_HI:OP_LO];
  assign rd_s    = in_instr[RD_HI:RD_LO];
  assign rs1_s   = in_instr[RS1_HI:RS1_LO];
  assign rs2_s   = in_instr[RS2_HI:RS2_LO];
  assign wr_en_s = op_writes_rd(op_s);
  assign read3_s = op_reads_rd(op_s);

  assign rf_rn1   = rs1_s;
  assign rf_rn2   = rs2_s;
  assign rf_rn3   = rd_s;
  assign rf_read3 = read3_s;

  // The register file returns the pre-write value during a write cycle.
  assign opa_s = (wb_en && (wb_addr == rs1_s)) ? wb_data : rf_a;
  assign opb_s = (wb_en && (wb_addr == rs2_s)) ? wb_data : rf_b;
  assign opc_s = !read3_s ? {REG_W{1'b0}}
               : ((wb_en && (wb_addr == rd_s)) ? wb_data : rf_c);

  reg_scoreboard u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (accept_s & wr_en_s),
    .set_addr (rd_s),
    .clr_en   (wb_en),
    .clr_addr (wb_addr),
    .q1_addr  (rs1_s),
    .q2_addr  (rs2_s),
    .q3_addr  (rd_s),
    .q1_block (blk1_s),
    .q2_block (blk2_s),
    .q3_block (blk3_s),
    .busy     (busy_s)
  );

  // The rd query serves both the third-source RAW check and the WAW check.
  assign hazard_s = blk1_s | blk2_s | ((read3_s | wr_en_s) & blk3_s);
  assign in_ready = (~out_valid_r | out_ready) & ~hazard_s;
  assign accept_s = in_valid & in_ready;

  // Output pipeline register: load on accept, drain when consumed, else hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_op_r    <= 4'h0;
      out_rd_r    <= {ADDR_W{1'b0}};
      out_wr_en_r <= 1'b0;
      out_a_r     <= {REG_W{1'b0}};
      out_b_r     <= {REG_W{1'b0}};
      out_c_r     <= {REG_W{1'b0}};
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_op_r    <= op_s;
      out_rd_r    <= rd_s;
      out_wr_en_r <= wr_en_s;
      out_a_r     <= opa_s;
      out_b_r     <= opb_s;
      out_c_r     <= opc_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Saturating count of cycles a valid instruction is held by a hazard.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (in_valid && hazard_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_op    = out_op_r;
  assign out_rd    = out_rd_r;
  assign out_wr_en = out_wr_en_r;
  assign out_a     = out_a_r;
  assign out_b     = out_b_r;
  assign out_c     = out_c_r;
  assign stall_cnt = stall_cnt_r;

  // Keep the full busy vector visible on the scoreboard instance.
  logic unused_busy_s;
  assign unused_busy_s = ^busy_s;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed, table-driven bench for operand_fetch with a behavioural register
// file (combinational read, write on the rising edge) behind the read ports.
module tb_operand_fetch;
  import isa_pkg::*;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       in_instr;
  logic [3:0]        rf_rn1, rf_rn2, rf_rn3;
  logic              rf_read3;
  logic [15:0]       rf_a, rf_b, rf_c;
  logic              wb_en;
  logic [3:0]        wb_addr;
  logic [15:0]       wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_op;
  logic [3:0]        out_rd;
  logic              out_wr_en;
  logic [15:0]       out_a, out_b, out_c;
  logic [15:0]       stall_cnt;

  logic [15:0] regs [16];

  int checks   = 0;
  int failures = 0;

  operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rf_rn1(rf_rn1), .rf_rn2(rf_rn2), .rf_rn3(rf_rn3), .rf_read3(rf_read3),
    .rf_a(rf_a), .rf_b(rf_b), .rf_c(rf_c),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_rd(out_rd), .out_wr_en(out_wr_en),
    .out_a(out_a), .out_b(out_b), .out_c(out_c),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_a = regs[rf_rn1];
  assign rf_b = regs[rf_rn2];
  assign rf_c = regs[rf_rn3];

  always @(posedge clk) begin
    if (wb_en) regs[wb_addr] <= wb_data;
  end

  typedef struct {
    logic [15:0] instr;
    logic        vld;
    logic        ordy;
    logic        wbe;
    logic [3:0]  wba;
    logic [15:0] wbd;
    logic        e_rdy;
    logic        e_rd3;
    logic        e_ov;
    logic [3:0]  e_op;
    logic [3:0]  e_rd;
    logic        e_wr;
    logic [15:0] e_a;
    logic [15:0] e_b;
    logic [15:0] e_c;
    logic [15:0] e_stall;
    logic [15:0] e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [15:0] instr, input logic vld, input logic ordy,
    input logic wbe, input logic [3:0] wba, input logic [15:0] wbd,
    input logic e_rdy, input logic e_rd3, input logic e_ov,
    input logic [3:0] e_op, input logic [3:0] e_rd, input logic e_wr,
    input logic [15:0] e_a, input logic [15:0] e_b, input logic [15:0] e_c,
    input logic [15:0] e_stall, input logic [15:0] e_busy);
    vec_t v;
    v.instr = instr; v.vld = vld; v.ordy = ordy;
    v.wbe = wbe; v.wba = wba; v.wbd = wbd;
    v.e_rdy = e_rdy; v.e_rd3 = e_rd3; v.e_ov = e_ov;
    v.e_op = e_op; v.e_rd = e_rd; v.e_wr = e_wr;
    v.e_a = e_a; v.e_b = e_b; v.e_c = e_c;
    v.e_stall = e_stall; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    vec_t v;
    for (int r = 0; r < 16; r++) regs[r] = 16'h0000;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = 16'h0000;
    out_ready = 1'b1;
    wb_en     = 1'b0;
    wb_addr   = 4'h0;
    wb_data   = 16'h0000;

    //        instr    v  ord wbe wba  wbd      rdy rd3 ov op    rd    wr  a        b        c        stall    busy
    vecs.push_back(mk(16'h0000,1'b0,1'b1,1'b1,4'h2,16'hABCD,1'b1,1'b0,1'b0,4'h0,4'h0,1'b0,16'h0,16'h0,16'h0,16'd0,16'h0000));
    vecs.push_back(mk(16'h0000,1'b0,1'b1,1'b1,4'h4,16'h3579,1'b1,1'b0,1'b0,4'h0,4'h0,1'b0,16'h0,16'h0,16'h0,16'd0,16'h0000));
    vecs.push_back(mk(16'h1324,1'b1,1'b1,1'b0,4'h0,16'h0000,1'b1,1'b0,1'b1,4'h1,4'h3,1'b1,16'hABCD,16'h3579,16'h0,16'd0,16'h0008));
    vecs.push_back(mk(16'h2535,1'b1,1'b1,1'b0,4'h0,16'h0000,1'b0,1'b0,1'b0,4'h0,4'h0,1'b0,16'h0,16'h0,16'h0,16'd1,16'h0008));
    vecs.push_back(mk(16'h2535,1'b1,1'b1,1'b0,4'h0,16'h0000,1'b0,1'b0,1'b0,4'h0,4'h0,1'b0,16'h0,16'h0,16'h0,16'd2,16'h0008));
    vecs.push_back(mk(16'h2535,1'b1,1'b1,1'b1,4'h3,16'h1111,1'b1,1'b0,1'b1,4'h2,4'h5,1'b1,16'h1111,16'h0,16'h0,16'd2,16'h0020));
    vecs.push_back(mk(16'h0000,1'b0,1'b1,1'b1,4'h1,16'h2468,1'b1,1'b0,1'b0,4'h0,4'h0,1'b0,16'h0,16'h0,16'h0,16'd2,16'h0020));
    vecs.push_back(mk(16'hC124,1'b1,1'b1,1'b0,4'h0,16'h0000,1'b1,1'b1,1'b1,4'hC,4'h1,1'b0,16'hABCD,16'h3579,16'h2468,16'd2,16'h0020));
    vecs.push_back(mk(16'h0000,1'b0,1'b1,1'b1,4'h2,16'h0000,1'b1,1'b0,1'b0,4'h0,4'h0,1'b0,16'h0,16'h0,16'h0,16'd2,16'h0020));
    vecs.push_back(mk(16'h8020,1'b1,1'b1,1'b1,4'h2,16'hFFFF,1'b1,1'b0,1'b1,4'h8,4'h0,1'b0,16'hFFFF,16'h0,16'h0,16'd2,16'h0020));
    vecs.push_back(mk(16'h0123,1'b1,1'b1,1'b0,4'h0,16'h0000,1'b1,1'b0,1'b1,4'h0,4'h1,1'b1,16'hFFFF,16'h1111,16'h0,16'd2,16'h0022));
    // back-pressure: outputs hold, no accept, stall counter untouched
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(16'h0640,1'b1,1'b0,1'b0,4'h0,16'h0000,1'b0,1'b0,1'b1,4'h0,4'h1,1'b1,16'hFFFF,16'h1111,16'h0,16'd2,16'h0022));
    vecs.push_back(mk(16'h0640,1'b1,1'b1,1'b0,4'h0,16'h0000,1'b1,1'b0,1'b1,4'h0,4'h6,1'b1,16'h3579,16'h0,16'h0,16'd2,16'h0062));
    vecs.push_back(mk(16'h0700,1'b1,1'b1,1'b0,4'h0,16'h0000,1'b1,1'b0,1'b1,4'h0,4'h7,1'b1,16'h0,16'h0,16'h0,16'd2,16'h00E2));
    // WAW on r7, then third-source RAW on busy r6
    vecs.push_back(mk(16'h0700,1'b1,1'b1,1'b0,4'h0,16'h0000,1'b0,1'b0,1'b0,4'h0,4'h0,1'b0,16'h0,16'h0,16'h0,16'd3,16'h00E2));
    vecs.push_back(mk(16'hD600,1'b1,1'b1,1'b0,4'h0,16'h0000,1'b0,1'b1,1'b0,4'h0,4'h0,1'b0,16'h0,16'h0,16'h0,16'd4,16'h00E2));
    vecs.push_back(mk(16'h0000,1'b0,1'b1,1'b0,4'h0,16'h0000,1'b1,1'b0,1'b0,4'h0,4'h0,1'b0,16'h0,16'h0,16'h0,16'd4,16'h00E2));

    repeat (2) @(negedge clk);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("reset out_a", {16'd0, out_a}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      in_instr  = v.instr;
      in_valid  = v.vld;
      out_ready = v.ordy;
      wb_en     = v.wbe;
      wb_addr   = v.wba;
      wb_data   = v.wbd;
      #2;
      chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, {31'd0, v.e_rdy});
      chk($sformatf("v%0d rf_read3", i), {31'd0, rf_read3}, {31'd0, v.e_rd3});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, v.e_ov});
      chk($sformatf("v%0d stall_cnt", i), {16'd0, stall_cnt}, {16'd0, v.e_stall});
      chk($sformatf("v%0d busy", i), {16'd0, dut.u_scoreboard.busy}, {16'd0, v.e_busy});
      if (v.e_ov) begin
        chk($sformatf("v%0d out_op", i), {28'd0, out_op}, {28'd0, v.e_op});
        chk($sformatf("v%0d out_rd", i), {28'd0, out_rd}, {28'd0, v.e_rd});
        chk($sformatf("v%0d out_wr_en", i), {31'd0, out_wr_en}, {31'd0, v.e_wr});
        chk($sformatf("v%0d out_a", i), {16'd0, out_a}, {16'd0, v.e_a});
        chk($sformatf("v%0d out_b", i), {16'd0, out_b}, {16'd0, v.e_b});
        chk($sformatf("v%0d out_c", i), {16'd0, out_c}, {16'd0, v.e_c});
      end
      @(negedge clk);
    end

    // Async reset while an instruction is held and another is stalled.
    in_instr = 16'h0840; in_valid = 1'b1; out_ready = 1'b0; wb_en = 1'b0;
    #2;
    chk("rs accept ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("rs held a", {16'd0, out_a}, {16'd0, 16'h3579});
    @(negedge clk);
    in_instr = 16'h2515;
    #2;
    chk("rs stall ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rs stall_cnt", {16'd0, stall_cnt}, 32'd5);
    chk("rs busy", {16'd0, dut.u_scoreboard.busy}, {16'd0, 16'h01E2});
    #1;
    rst = 1'b1;
    #1;
    chk("rs out_valid", {31'd0, out_valid}, 32'd0);
    chk("rs stall_cnt0", {16'd0, stall_cnt}, 32'd0);
    chk("rs busy0", {16'd0, dut.u_scoreboard.busy}, 32'd0);
    chk("rs out_a0", {16'd0, out_a}, 32'd0);
    chk("rs in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("post rs ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("post rs issue", {31'd0, out_valid}, 32'd1);
    chk("post rs op", {28'd0, out_op}, 32'd2);
    in_valid = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
